// File: rtl/count_seg_display.sv
// count_seg_display
// Two-digit multiplexed 7-segment driver for a 4-bit counter value (00..15).
// Scans ones/tens at a programmable slot length, latches the value once per
// frame so both digits always describe the same number, optionally blanks a
// leading zero, and shows a sticky 15->0 wrap indicator on the ones-digit
// decimal point.

module count_seg_display #(
   parameter int unsigned REFRESH_DIV        = 50000,
   parameter bit          SEG_ACTIVE_LOW     = 1'b1,
   parameter bit          BLANK_LEADING_ZERO = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] count,
   input  logic       dp_clear,
   output logic [6:0] seg,
   output logic       dp,
   output logic [1:0] an,
   output logic       wrap_flag
);

   localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);

   // Inactive drive levels depend on output polarity
   localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic       DP_OFF  = SEG_ACTIVE_LOW ? 1'b1  : 1'b0;
   localparam logic [1:0] AN_OFF  = SEG_ACTIVE_LOW ? 2'b11 : 2'b00;

   // State registers
   logic [PW-1:0] presc_q,       presc_d;
   logic          digit_sel_q,   digit_sel_d;
   logic [3:0]    display_val_q, display_val_d;
   logic [3:0]    prev_q;
   logic          wrap_flag_q,   wrap_flag_d;

   // Output registers
   logic [6:0]    seg_q, seg_d;
   logic          dp_q,  dp_d;
   logic [1:0]    an_q,  an_d;

   // Combinational helpers
   logic          tick;
   logic          wrap;
   logic          tens_digit;
   logic [3:0]    ones_digit;
   logic [6:0]    seg_hi;
   logic          dp_hi;
   logic [1:0]    an_hi;

   // Active-high segment pattern (g..a) for a decimal digit
   function automatic logic [6:0] seg_encode(input logic [3:0] digit);
      logic [6:0] pat;
      case (digit)
         4'd0:    pat = 7'h3F;
         4'd1:    pat = 7'h06;
         4'd2:    pat = 7'h5B;
         4'd3:    pat = 7'h4F;
         4'd4:    pat = 7'h66;
         4'd5:    pat = 7'h6D;
         4'd6:    pat = 7'h7D;
         4'd7:    pat = 7'h07;
         4'd8:    pat = 7'h7F;
         4'd9:    pat = 7'h6F;
         default: pat = 7'h00;
      endcase
      return pat;
   endfunction

   // Prescaler, digit select, frame latch and sticky wrap next-state
   always_comb begin
      tick          = (presc_q == PRESC_MAX);
      presc_d       = tick ? '0 : presc_q + 1'b1;
      digit_sel_d   = tick ? ~digit_sel_q : digit_sel_q;
      // Latch only at the end of the tens slot so a new value starts a frame
      display_val_d = (tick && digit_sel_q) ? count : display_val_q;
      // Only a genuine 15->0 step counts; set has priority over clear
      wrap          = (prev_q == 4'hF) && (count == 4'h0);
      if (wrap)
         wrap_flag_d = 1'b1;
      else if (dp_clear)
         wrap_flag_d = 1'b0;
      else
         wrap_flag_d = wrap_flag_q;
   end

   // Decimal split and output pattern for the slot currently selected
   always_comb begin
      tens_digit = (display_val_q >= 4'd10);
      ones_digit = tens_digit ? (display_val_q - 4'd10) : display_val_q;
      if (digit_sel_q) begin
         an_hi  = 2'b10;
         dp_hi  = 1'b0;
         if (!tens_digit && BLANK_LEADING_ZERO)
            seg_hi = 7'h00;
         else
            seg_hi = seg_encode({3'b000, tens_digit});
      end else begin
         an_hi  = 2'b01;
         dp_hi  = wrap_flag_q;
         seg_hi = seg_encode(ones_digit);
      end
      // Polarity applied once, just ahead of the output registers
      seg_d = SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
      dp_d  = SEG_ACTIVE_LOW ? ~dp_hi  : dp_hi;
      an_d  = SEG_ACTIVE_LOW ? ~an_hi  : an_hi;
   end

   // Scan and wrap state with immediate reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc_q       <= '0;
         digit_sel_q   <= 1'b0;
         display_val_q <= 4'd0;
         prev_q        <= 4'd0;
         wrap_flag_q   <= 1'b0;
      end else begin
         presc_q       <= presc_d;
         digit_sel_q   <= digit_sel_d;
         display_val_q <= display_val_d;
         prev_q        <= count;
         wrap_flag_q   <= wrap_flag_d;
      end
   end

   // Registered display drive, parked at inactive level during reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         seg_q <= SEG_OFF;
         dp_q  <= DP_OFF;
         an_q  <= AN_OFF;
      end else begin
         seg_q <= seg_d;
         dp_q  <= dp_d;
         an_q  <= an_d;
      end
   end

   assign seg       = seg_q;
   assign dp        = dp_q;
   assign an        = an_q;
   assign wrap_flag = wrap_flag_q;

endmodule

// File: tb/tb_count_seg_display.sv
// Directed bench for count_seg_display, REFRESH_DIV=4, active-low outputs.
// A second instance with leading-zero blanking disabled shares the inputs.

module tb_count_seg_display;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] count;
   logic       dp_clear;
   logic [6:0] seg, seg_nb;
   logic       dp, dp_nb;
   logic [1:0] an, an_nb;
   logic       wrap_flag, wrap_flag_nb;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   always #5 clk = ~clk;

   count_seg_display #(
      .REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b1), .BLANK_LEADING_ZERO(1'b1)
   ) dut (
      .clk(clk), .reset(reset), .count(count), .dp_clear(dp_clear),
      .seg(seg), .dp(dp), .an(an), .wrap_flag(wrap_flag)
   );

   count_seg_display #(
      .REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b1), .BLANK_LEADING_ZERO(1'b0)
   ) dut_nb (
      .clk(clk), .reset(reset), .count(count), .dp_clear(dp_clear),
      .seg(seg_nb), .dp(dp_nb), .an(an_nb), .wrap_flag(wrap_flag_nb)
   );

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
      end
      $display("check %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
   endtask

   // One posedge, then settle at the following negedge
   task automatic step();
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic run_to(input int target);
      while (cyc < target) step();
   endtask

   initial begin
      reset = 1'b1; count = 4'd0; dp_clear = 1'b0;
      @(negedge clk); @(negedge clk);
      check("rst_an",   {6'd0, an},   8'h03);
      check("rst_seg",  {1'b0, seg},  8'h7F);
      check("rst_dp",   {7'd0, dp},   8'h01);
      check("rst_wrap", {7'd0, wrap_flag}, 8'h00);

      // Release and show "0" on ones at the first edge
      reset = 1'b0; count = 4'd7; cyc = 0;
      step();
      check("first_an",  {6'd0, an},  8'h02);
      check("first_seg", {1'b0, seg}, 8'h40);
      check("first_dp",  {7'd0, dp},  8'h01);
      // Slots alternate every 4 cycles
      for (int k = 2; k <= 16; k++) begin
         step();
         check("scan_an", {6'd0, an}, (((k - 1) / 4) % 2 == 0) ? 8'h02 : 8'h01);
         if (k == 10) check("seven_ones", {1'b0, seg}, 8'h78);
         if (k == 14) begin
            check("seven_tens_blank", {1'b0, seg}, 8'h7F);
            check("seven_tens_noblank", {1'b0, seg_nb}, 8'h40);
         end
      end

      // Two digits: 13
      count = 4'd13;
      run_to(26); check("13_ones", {1'b0, seg}, 8'h30);
      run_to(30); check("13_tens", {1'b0, seg}, 8'h79);
      check("13_tens_an", {6'd0, an}, 8'h01);

      // 4 with and without blanking
      run_to(32); count = 4'd4;
      run_to(42); check("4_ones", {1'b0, seg}, 8'h19);
      run_to(46); check("4_tens_noblank", {1'b0, seg_nb}, 8'h40);
      check("4_tens_blank", {1'b0, seg}, 8'h7F);

      // Wrap 14,15,0
      run_to(48); count = 4'd14;
      step();     count = 4'd15;
      step();     count = 4'd0;
      check("wrap_not_yet", {7'd0, wrap_flag}, 8'h00);
      step();     check("wrap_set", {7'd0, wrap_flag}, 8'h01);
      step();     check("wrap_dp_ones", {7'd0, dp}, 8'h00);
      run_to(54); check("wrap_dp_tens", {7'd0, dp}, 8'h01);

      // Clear
      run_to(56); dp_clear = 1'b1;
      step();     dp_clear = 1'b0;
      check("clear_flag", {7'd0, wrap_flag}, 8'h00);
      step();     check("clear_dp", {7'd0, dp}, 8'h01);

      // Set wins over simultaneous clear
      count = 4'd15;
      step();     count = 4'd0; dp_clear = 1'b1;
      step();     dp_clear = 1'b1;
      check("set_wins", {7'd0, wrap_flag}, 8'h01);
      step();     dp_clear = 1'b0;
      check("clear_again", {7'd0, wrap_flag}, 8'h00);

      // 7 -> 0 is not a wrap
      count = 4'd7;
      step();     count = 4'd0;
      step();
      step();     check("no_wrap_7_0", {7'd0, wrap_flag}, 8'h00);
      step();     check("no_wrap_7_0b", {7'd0, wrap_flag}, 8'h00);

      // Frame coherency: 9 then 12 mid tens slot
      count = 4'd9;
      run_to(76); check("9_ones", {1'b0, seg}, 8'h10);
      run_to(78); count = 4'd12;
      step();     check("9_tens_hold", {1'b0, seg}, 8'h7F);
      check("9_tens_an", {6'd0, an}, 8'h01);
      run_to(82); check("12_ones", {1'b0, seg}, 8'h24);
      run_to(86); check("12_tens", {1'b0, seg}, 8'h79);

      // Reset mid-scan with 11 shown, tens slot, presc=2
      count = 4'd11;
      run_to(90); check("11_ones", {1'b0, seg}, 8'h79);
      run_to(94); check("11_tens_an", {6'd0, an}, 8'h01);
      check("11_tens", {1'b0, seg}, 8'h79);
      check("presc_2", {6'd0, dut.presc_q}, 8'h02);
      #1 reset = 1'b1;
      #1;
      check("mid_rst_an",  {6'd0, an},  8'h03);
      check("mid_rst_seg", {1'b0, seg}, 8'h7F);
      check("mid_rst_dp",  {7'd0, dp},  8'h01);
      @(negedge clk);
      reset = 1'b0; cyc = 0;
      step();     check("restart_an",  {6'd0, an},  8'h02);
      check("restart_seg", {1'b0, seg}, 8'h40);
      run_to(4);  check("restart_seg4", {1'b0, seg}, 8'h40);
      step();     check("restart_tens_an", {6'd0, an}, 8'h01);
      check("restart_tens_blank", {1'b0, seg}, 8'h7F);
      run_to(9);  check("restart_11_ones", {1'b0, seg}, 8'h79);
      check("restart_an9", {6'd0, an}, 8'h02);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/count_seg_display.md
# count_seg_display

Downstream display stage for the 4-bit counter. Takes the counter's `count[3:0]` (same `clk` domain) and converts it to two decimal digits, 00–15. It drives a two-digit multiplexed 7-segment display with a programmable scan rate and optional leading-zero blanking. It also keeps a sticky wrap indicator (15→0), shown on the ones-digit decimal point.

## Interface
- `REFRESH_DIV`, default 50000: clk cycles per digit slot; legal range ≥ 2; prescaler width = $clog2(REFRESH_DIV).
- `SEG_ACTIVE_LOW`, default 1: 1 means `seg`, `dp` and `an` are all active-low; 0 means all are active-high.
- `BLANK_LEADING_ZERO`, default 1: 1 means a tens digit of 0 is shown blank.
- `clk` input, 1 bit: clock, rising edge.
- `reset` input, 1 bit: asynchronous, active-high.
- `count` input, 4 bits: counter value, synchronous to clk.
- `dp_clear` input, 1 bit: single-cycle pulse that clears `wrap_flag`.
- `seg` output, 7 bits: segment drive, `seg[0]`=a … `seg[6]`=g.
- `dp` output, 1 bit: decimal point drive.
- `an` output, 2 bits: digit enables; `an[0]` = ones, `an[1]` = tens.
- `wrap_flag` output, 1 bit: sticky flag for a 15→0 transition; always active-high.

## Operation
- **Prescaler.** `presc` counts 0…REFRESH_DIV-1 and wraps. `tick` = (`presc` == REFRESH_DIV-1).
- **Digit select.** `digit_sel` (0 = ones, 1 = tens) toggles on every tick edge.
- **Frame latch.** On a tick edge with `digit_sel`==1, `display_val` <= `count`. The value therefore changes only at frame start; a frame is 2·REFRESH_DIV cycles. Changes to `count` mid-frame are not shown until the next latch.
- **Decimal conversion.** tens = (`display_val` ≥ 10). ones = `display_val` − 10·tens, computed in 4 bits with no overflow.
- **Segment encoding** (active-high form, g..a):
  - 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66
  - 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F
  - When SEG_ACTIVE_LOW=1, the pattern is inverted at the output register.
- **Leading-zero blanking.** When tens==0 and BLANK_LEADING_ZERO=1, the tens slot drives all segments off. `an[1]` is still asserted during that slot.
- **Wrap detect.**
  - `prev` <= `count` every cycle.
  - wrap = (`prev`==4'hF && `count`==4'h0).
  - `wrap_flag` is set by wrap and cleared by `dp_clear`. If both occur in the same cycle, set wins.
  - Any other transition into 0 (for example a counter reset from 7) does not set the flag.
- **DP drive.** `dp` is asserted only during the ones slot when `wrap_flag`==1. It is never asserted in the tens slot.
- **Register state:** `presc`, `digit_sel`, `display_val`, `prev`, `wrap_flag`, plus output registers for `seg`, `dp` and `an`.

## Timing
- **Reset (asynchronous, immediate).**
  - `presc`=0, `digit_sel`=0, `display_val`=0, `prev`=0, `wrap_flag`=0.
  - `seg`, `dp` and `an` are all at inactive level: 7'h7F / 1 / 2'b11 for active-low, 7'h00 / 0 / 2'b00 for active-high.
- **First edge after reset release.** `an` selects ones and `seg` shows "0".
- **Output latency.** `seg`, `dp` and `an` are registered from the current `digit_sel`, `display_val` and `wrap_flag`. They change one edge after `digit_sel` toggles.
- **Slot length.** Each digit is enabled for exactly REFRESH_DIV cycles, and exactly one `an` bit is active at any time after the first post-reset edge.
- **Wrap flag latency.**
  - `wrap_flag` rises on the edge after the cycle in which `count`==0 follows 15.
  - `dp` reflects the flag one edge later, or at the next ones slot if the tens slot is currently active.
  - `dp_clear` takes effect on the next edge.
- **Reset mid-scan.** All state is cleared immediately, regardless of `presc` or `digit_sel`. Scanning restarts at the ones digit.

## Test plan
All scenarios use REFRESH_DIV=4 and SEG_ACTIVE_LOW=1.
- **Reset:** assert `reset` → `an`=2'b11, `seg`=7'h7F, `dp`=1, `wrap_flag`=0. Release → next edge `an`=2'b10, `seg`=7'h40; `an` alternates every 4 cycles.
- **Single digit:** hold `count`=7 for 2 frames → ones slot `seg`=7'h78; tens slot `an`=2'b01, `seg`=7'h7F (blanked).
- **Two digits:** hold `count`=13 → tens `seg`=7'h79 ("1"), ones `seg`=7'h30 ("3"). Repeat with BLANK_LEADING_ZERO=0 and `count`=4 → tens `seg`=7'h40 ("0").
- **Wrap:**
  - `count` 14, 15, 0 on consecutive cycles → `wrap_flag`=1 and `dp`=0 during the ones slot.
  - Pulse `dp_clear` → `wrap_flag`=0.
  - Repeat with `dp_clear` pulsed in the same cycle as the 15→0 transition → `wrap_flag` stays 1.
  - `count` 7→0 does not set `wrap_flag`.
- **Frame coherency:** change `count` from 9 to 12 in the middle of the tens slot → the displayed value stays 9 until the next latch, then shows tens "1", ones "2" (`seg`=7'h24).
- **Reset mid-scan:** with `count`=11 displayed, assert `reset` at `presc`=2 during the tens slot → outputs go inactive immediately. After release, scanning restarts at the ones slot showing "0" until the first latch.
